// File: rtl/tdp_ram_child_min_ctrl.sv
// tdp_ram_child_min_ctrl: dual-port RAM initiator returning the smaller child of a parent, plus single-port writes
module tdp_ram_child_min_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_op_i,
  input  logic [31:0]      cmd_addr_i,
  input  logic [WIDTH-1:0] cmd_data_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_min_o,
  output logic [31:0]      rsp_addr_o,
  output logic             rsp_err_o,
  output logic             ram_ena_o,
  output logic             ram_wea_o,
  output logic [31:0]      ram_addra_o,
  output logic [WIDTH-1:0] ram_dia_o,
  input  logic [WIDTH-1:0] ram_doa_i,
  output logic             ram_enb_o,
  output logic             ram_web_o,
  output logic [31:0]      ram_addrb_o,
  output logic [WIDTH-1:0] ram_dib_o,
  input  logic [WIDTH-1:0] ram_dob_i
);
  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, RESP, WRITE} state_t;
  state_t state_q, state_d;
  logic [33:0] left, right;
  logic inl, inr, acc, selr;
  logic inl_q, inl_d, inr_q, inr_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0] rsp_min_q, rsp_min_d, ram_dia_q, ram_dia_d;
  logic [31:0] rsp_addr_q, rsp_addr_d, ram_addra_q, ram_addra_d, ram_addrb_q, ram_addrb_d;
  logic ram_ena_q, ram_ena_d, ram_wea_q, ram_wea_d, ram_enb_q, ram_enb_d;
  assign cmd_ready_o = (state_q == IDLE) && rst_ni;
  assign acc   = cmd_valid_i && cmd_ready_o;
  assign left  = {1'b0, cmd_addr_i, 1'b1};
  assign right = left + 34'd1;
  assign inl   = left < 34'(DEPTH);
  assign inr   = right < 34'(DEPTH);
  assign selr  = inr_q && (ram_dob_i < ram_doa_i);
  always_comb begin
    state_d     = state_q;
    inl_d       = inl_q;
    inr_d       = inr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_min_d   = rsp_min_q;
    rsp_addr_d  = rsp_addr_q;
    ram_ena_d   = 1'b0;
    ram_wea_d   = 1'b0;
    ram_enb_d   = 1'b0;
    ram_addra_d = ram_addra_q;
    ram_addrb_d = ram_addrb_q;
    ram_dia_d   = ram_dia_q;
    case (state_q)
      IDLE: if (acc) begin
        if (cmd_op_i) begin
          state_d     = WRITE;
          ram_ena_d   = cmd_addr_i < 32'(DEPTH);
          ram_wea_d   = cmd_addr_i < 32'(DEPTH);
          ram_addra_d = cmd_addr_i;
          ram_dia_d   = cmd_data_i;
        end else begin
          state_d     = ISSUE;
          ram_ena_d   = inl;
          ram_enb_d   = inr;
          ram_addra_d = left[31:0];
          ram_addrb_d = right[31:0];
          inl_d       = inl;
          inr_d       = inr;
        end
      end
      ISSUE: state_d = CAPTURE;
      CAPTURE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = !inl_q;
        rsp_min_d   = !inl_q ? '1 : (selr ? ram_dob_i : ram_doa_i);
        rsp_addr_d  = selr ? ram_addrb_q : ram_addra_q;
      end
      RESP: if (rsp_ready_i) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
      WRITE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      inl_q       <= 1'b0;
      inr_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_min_q   <= '0;
      rsp_addr_q  <= '0;
      ram_ena_q   <= 1'b0;
      ram_wea_q   <= 1'b0;
      ram_enb_q   <= 1'b0;
      ram_addra_q <= '0;
      ram_addrb_q <= '0;
      ram_dia_q   <= '0;
    end else begin
      state_q     <= state_d;
      inl_q       <= inl_d;
      inr_q       <= inr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_min_q   <= rsp_min_d;
      rsp_addr_q  <= rsp_addr_d;
      ram_ena_q   <= ram_ena_d;
      ram_wea_q   <= ram_wea_d;
      ram_enb_q   <= ram_enb_d;
      ram_addra_q <= ram_addra_d;
      ram_addrb_q <= ram_addrb_d;
      ram_dia_q   <= ram_dia_d;
    end
  end
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_min_o   = rsp_min_q;
  assign rsp_addr_o  = rsp_addr_q;
  assign ram_ena_o   = ram_ena_q;
  assign ram_wea_o   = ram_wea_q;
  assign ram_addra_o = ram_addra_q;
  assign ram_dia_o   = ram_dia_q;
  assign ram_enb_o   = ram_enb_q;
  assign ram_web_o   = 1'b0;
  assign ram_addrb_o = ram_addrb_q;
  assign ram_dib_o   = '0;
endmodule

// File: tb/tb_tdp_ram_child_min_ctrl.sv
// tb_tdp_ram_child_min_ctrl: directed self-checking bench with a behavioural dual-port RAM
module tb_tdp_ram_child_min_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [15:0] rsp_min;
  logic [31:0] rsp_addr;
  logic ram_ena, ram_wea, ram_enb, ram_web;
  logic [31:0] ram_addra, ram_addrb;
  logic [15:0] ram_dia, ram_dib, ram_doa, ram_dob;
  logic [15:0] mem [0:1023];
  logic pl_en = 1'b0;
  logic [9:0] pl_a = '0;
  logic [15:0] pl_d = '0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  tdp_ram_child_min_ctrl #(.WIDTH(16), .DEPTH(1024)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_min_o(rsp_min),
    .rsp_addr_o(rsp_addr), .rsp_err_o(rsp_err),
    .ram_ena_o(ram_ena), .ram_wea_o(ram_wea), .ram_addra_o(ram_addra),
    .ram_dia_o(ram_dia), .ram_doa_i(ram_doa),
    .ram_enb_o(ram_enb), .ram_web_o(ram_web), .ram_addrb_o(ram_addrb),
    .ram_dib_o(ram_dib), .ram_dob_i(ram_dob)
  );
  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    if (ram_ena && ram_addra < 32'd1024) begin
      if (ram_wea) mem[ram_addra[9:0]] <= ram_dia;
      ram_doa <= mem[ram_addra[9:0]];
    end
    if (ram_enb && ram_addrb < 32'd1024) begin
      if (ram_web) mem[ram_addrb[9:0]] <= ram_dib;
      ram_dob <= mem[ram_addrb[9:0]];
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    tick();
    pl_en = 1'b0;
  endtask
  task automatic do_read(input logic [31:0] a, output logic [15:0] mn, output logic [31:0] ra,
                         output logic er, output int lat, output int pa, output int pb);
    int n;
    n = 0; pa = 0; pb = 0; mn = 'x; ra = 'x; er = 'x;
    cmd_op = 1'b0; cmd_addr = a; cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    if (!cmd_ready) begin cmd_valid = 1'b0; lat = -1; return; end
    tick();
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      pa += int'(ram_ena); pb += int'(ram_enb);
      tick(); lat++;
    end
    if (!rsp_valid) lat = -1;
    mn = rsp_min; ra = rsp_addr; er = rsp_err;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask
  task automatic do_write(input logic [31:0] a, input logic [15:0] d, output int pa);
    int n;
    n = 0; pa = 0;
    cmd_op = 1'b1; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    if (!cmd_ready) begin cmd_valid = 1'b0; pa = -1; return; end
    tick();
    cmd_valid = 1'b0;
    pa += int'(ram_ena && ram_wea);
    tick();
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    tests++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_cmd_ready got %b want 0", cmd_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    tests++; if ({ram_ena, ram_wea, ram_enb} !== 3'b000) begin fails++; $display("FAIL reset_enables got %b want 000", {ram_ena, ram_wea, ram_enb}); end
    tests++; if ({rsp_min, rsp_err} !== 17'h0) begin fails++; $display("FAIL reset_rsp_data got %h want 0", {rsp_min, rsp_err}); end
    tests++; if ({rsp_addr, ram_addra, ram_addrb} !== 96'h0) begin fails++; $display("FAIL reset_addrs got %h want 0", {rsp_addr, ram_addra, ram_addrb}); end
    tests++; if ({ram_dia, ram_dib, ram_web} !== 33'h0) begin fails++; $display("FAIL reset_wdata got %h want 0", {ram_dia, ram_dib, ram_web}); end
    rst_n = 1'b1;
    #1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL release_cmd_ready got %b want 1", cmd_ready); end
  endtask
  task automatic test_basic_read();
    logic [15:0] mn; logic [31:0] ra; logic er; int lat, pa, pb;
    preload(10'd1, 16'h0030);
    preload(10'd2, 16'h0010);
    do_read(32'd0, mn, ra, er, lat, pa, pb);
    tests++; if (lat !== 3) begin fails++; $display("FAIL basic_latency got %0d want 3", lat); end
    tests++; if (mn !== 16'h0010) begin fails++; $display("FAIL basic_min got %h want 0010", mn); end
    tests++; if (ra !== 32'd2) begin fails++; $display("FAIL basic_addr got %0d want 2", ra); end
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL basic_err got %b want 0", er); end
    tests++; if (pa !== 1 || pb !== 1) begin fails++; $display("FAIL basic_pulses got %0d/%0d want 1/1", pa, pb); end
    tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin fails++; $display("FAIL basic_after_hs got %b/%b want 0/1", rsp_valid, cmd_ready); end
  endtask
  task automatic test_tie();
    logic [15:0] mn; logic [31:0] ra; logic er; int lat, pa, pb;
    preload(10'd5, 16'h00AA);
    preload(10'd6, 16'h00AA);
    do_read(32'd2, mn, ra, er, lat, pa, pb);
    tests++; if (mn !== 16'h00AA || ra !== 32'd5 || er !== 1'b0) begin fails++; $display("FAIL tie got %h@%0d err %b want 00aa@5 err 0", mn, ra, er); end
  endtask
  task automatic test_boundary();
    logic [15:0] mn; logic [31:0] ra; logic er; int lat, pa, pb;
    preload(10'd1023, 16'h1234);
    preload(10'd0, 16'h0001);
    do_read(32'd511, mn, ra, er, lat, pa, pb);
    tests++; if (pa !== 1 || pb !== 0) begin fails++; $display("FAIL b511_pulses got %0d/%0d want 1/0", pa, pb); end
    tests++; if (mn !== 16'h1234 || ra !== 32'd1023 || er !== 1'b0) begin fails++; $display("FAIL b511_rsp got %h@%0d err %b want 1234@1023 err 0", mn, ra, er); end
    do_read(32'd512, mn, ra, er, lat, pa, pb);
    tests++; if (pa !== 0 || pb !== 0) begin fails++; $display("FAIL b512_pulses got %0d/%0d want 0/0", pa, pb); end
    tests++; if (mn !== 16'hFFFF || ra !== 32'd1025 || er !== 1'b1) begin fails++; $display("FAIL b512_rsp got %h@%0d err %b want ffff@1025 err 1", mn, ra, er); end
    tests++; if (lat !== 3) begin fails++; $display("FAIL b512_latency got %0d want 3", lat); end
    do_read(32'hFFFF_FFFF, mn, ra, er, lat, pa, pb);
    tests++; if (pa !== 0 || pb !== 0) begin fails++; $display("FAIL bmax_pulses got %0d/%0d want 0/0", pa, pb); end
    tests++; if (mn !== 16'hFFFF || ra !== 32'hFFFF_FFFF || er !== 1'b1) begin fails++; $display("FAIL bmax_rsp got %h@%h err %b want ffff@ffffffff err 1", mn, ra, er); end
  endtask
  task automatic test_write_then_read();
    logic [15:0] mn; logic [31:0] ra; logic er; int lat, pa, pb, wp;
    preload(10'd4, 16'h0002);
    preload(10'd3, 16'h5555);
    do_write(32'd3, 16'h0001, wp);
    tests++; if (wp !== 1) begin fails++; $display("FAIL write_pulse got %0d want 1", wp); end
    do_read(32'd1, mn, ra, er, lat, pa, pb);
    tests++; if (mn !== 16'h0001 || ra !== 32'd3 || er !== 1'b0) begin fails++; $display("FAIL wr_read got %h@%0d err %b want 0001@3 err 0", mn, ra, er); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL write_no_rsp got %b want 0", rsp_valid); end
    do_write(32'd1024, 16'hBEEF, wp);
    tests++; if (wp !== 0 || ram_ena !== 1'b0) begin fails++; $display("FAIL write_oor got %0d want 0", wp); end
    tests++; if (mem[0] !== 16'h0001) begin fails++; $display("FAIL write_oor_wrap got %h want 0001", mem[0]); end
  endtask
  task automatic test_backpressure();
    logic [15:0] mn; logic [31:0] ra; int n;
    cmd_op = 1'b0; cmd_addr = 32'd0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_rsp_timeout got %b want 1", rsp_valid); end
    mn = rsp_min; ra = rsp_addr;
    tests++; if (mn !== 16'h0010 || ra !== 32'd2) begin fails++; $display("FAIL bp_rsp got %h@%0d want 0010@2", mn, ra); end
    cmd_addr = 32'd2; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (rsp_valid !== 1'b1 || rsp_min !== mn || rsp_addr !== ra || cmd_ready !== 1'b0 || ram_ena !== 1'b0) begin
        fails++; $display("FAIL bp_hold%0d got v%b %h@%0d rdy%b ena%b want v1 %h@%0d rdy0 ena0", i, rsp_valid, rsp_min, rsp_addr, cmd_ready, ram_ena, mn, ra);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tests++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || ram_ena !== 1'b0) begin fails++; $display("FAIL bp_handshake got v%b rdy%b ena%b want v0 rdy1 ena0", rsp_valid, cmd_ready, ram_ena); end
    tick();
    cmd_valid = 1'b0;
    tests++; if (ram_ena !== 1'b1 || ram_addra !== 32'd5 || ram_addrb !== 32'd6) begin fails++; $display("FAIL bp_accept got ena%b %0d/%0d want ena1 5/6", ram_ena, ram_addra, ram_addrb); end
    n = 0;
    while (!rsp_valid && n < 20) begin tick(); n++; end
    tests++; if (rsp_valid !== 1'b1 || rsp_min !== 16'h00AA || rsp_addr !== 32'd5) begin fails++; $display("FAIL bp_second got v%b %h@%0d want v1 00aa@5", rsp_valid, rsp_min, rsp_addr); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask
  task automatic test_reset_mid();
    logic [15:0] mn; logic [31:0] ra; logic er; int lat, pa, pb;
    cmd_op = 1'b0; cmd_addr = 32'd0; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    tests++; if (rsp_valid !== 1'b0 || ram_ena !== 1'b0 || ram_enb !== 1'b0 || cmd_ready !== 1'b0) begin fails++; $display("FAIL mid_reset got v%b ena%b enb%b rdy%b want 0000", rsp_valid, ram_ena, ram_enb, cmd_ready); end
    rst_n = 1'b1;
    #1;
    tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL mid_release got %b want 1", cmd_ready); end
    tick();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_dropped got %b want 0", rsp_valid); end
    do_read(32'd2, mn, ra, er, lat, pa, pb);
    tests++; if (lat !== 3 || mn !== 16'h00AA || ra !== 32'd5 || er !== 1'b0) begin fails++; $display("FAIL mid_fresh got lat%0d %h@%0d err %b want lat3 00aa@5 err 0", lat, mn, ra, er); end
  endtask
  initial begin
    test_reset();
    test_basic_read();
    test_tie();
    test_boundary();
    test_write_then_read();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tdp_ram_child_min_ctrl.md
Name: tdp_ram_child_min_ctrl

Overview:
- Initiator that drives both ports of the hybrid tree's true-dual-port level RAM. Used by the tree's sift logic.
- Read command: takes a parent index `i`, reads children `2i+1` (port A) and `2i+2` (port B) in the same cycle, then returns the smaller child and its address.
- Write command: stores one entry through port A.
- Owns all RAM enables and addresses; the RAM itself sits outside the block.

Parameters:
- WIDTH, 16, entry width in bits.
- DEPTH, 1024, number of valid RAM entries; valid addresses are 0..DEPTH-1.

Ports:
- clk  in  1  single clock for the block and both RAM ports.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  1  0 = child-min read, 1 = write.
- cmd_addr  in  32  parent index (read) or target address (write).
- cmd_data  in  WIDTH  write data (ignored for reads).
- rsp_valid  out  1  read response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_min  out  WIDTH  smaller child value.
- rsp_addr  out  32  address of the selected child.
- rsp_err  out  1  both children out of range.
- ram_ena, ram_wea  out  1 each  port A enable and write enable.
- ram_addra  out  32  port A address.
- ram_dia  out  WIDTH  port A write data.
- ram_doa  in  WIDTH  port A read data; registered, valid 1 cycle after ram_ena.
- ram_enb, ram_web  out  1 each  port B enable and write enable (ram_web is always 0).
- ram_addrb  out  32  port B address.
- ram_dib  out  WIDTH  port B write data (always 0).
- ram_dob  in  WIDTH  port B read data.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state goes to IDLE.
  - All registered outputs clear to 0: rsp_valid, rsp_min, rsp_addr, rsp_err, all ram_* outputs.
  - cmd_ready is 0 while rst_n=0.
  - Reset in any state aborts the operation. No RAM access is issued on the following edge, and any pending response is dropped.
- States: IDLE, ISSUE, CAPTURE, RESP, WRITE. cmd_ready = (state==IDLE) and rst_n.
- IDLE, on cmd_valid & cmd_ready:
  - Latch op, address and data.
  - op=0 goes to ISSUE; op=1 goes to WRITE.
- Read address computation (in the accept cycle):
  - Compute left = 2*cmd_addr+1 and right = 2*cmd_addr+2 at 34-bit width.
  - inL = left < DEPTH; inR = right < DEPTH.
  - Because right = left+1, inR implies inL.
- ISSUE:
  - ram_ena = inL, ram_addra = left[31:0]; ram_enb = inR, ram_addrb = right[31:0]; ram_wea = ram_web = 0.
  - Ports for out-of-range children stay disabled. Their address outputs are don't-care but must equal the computed value truncated to 32 bits.
  - Next state is CAPTURE.
- CAPTURE: all RAM enables are 0; sample ram_doa/ram_dob and register the result. Next state is RESP, with rsp_valid=1 on entry.
  - inL & inR: take the smaller value; on a tie (ram_doa == ram_dob) select left.
  - inL only: select left.
  - neither in range: rsp_err=1, rsp_min = all ones, rsp_addr = left[31:0].
- RESP:
  - Hold rsp_* stable while rsp_ready=0.
  - On rsp_ready=1: rsp_valid falls at the next edge and state returns to IDLE.
  - Earliest next command accept is the cycle after the response handshake. No back-to-back overlap.
- Read latency: accept at edge 0 → ram_ena high in cycle 1 → data sampled at edge 2 → rsp_valid high in cycle 3 (3 cycles).
- WRITE:
  - Issued only if cmd_addr < DEPTH: ram_ena=1, ram_wea=1, ram_addra=addr, ram_dia=data for exactly one cycle.
  - Out-of-range writes are silently dropped (no enable).
  - Returns to IDLE the next cycle. Writes produce no response.
  - A read accepted immediately after a write issues at least one cycle after the write edge, so it observes the new data.
- Port B never writes, so there are no write-write collisions.
- cmd_* inputs are ignored when cmd_ready=0.

Test Plan:
- Basic read: preload RAM[1]=0x0030, RAM[2]=0x0010; read cmd_addr=0 → rsp_valid in 3rd cycle after accept, rsp_min=0x0010, rsp_addr=2, rsp_err=0.
- Tie: RAM[5]=RAM[6]=0x00AA; read cmd_addr=2 → rsp_min=0x00AA, rsp_addr=5.
- Boundaries (DEPTH=1024):
  - cmd_addr=511 (left=1023, right=1024) → only ram_ena pulses; rsp_addr=1023, rsp_min=RAM[1023].
  - cmd_addr=512 → no enables; rsp_err=1, rsp_min=0xFFFF, rsp_addr=1025.
  - cmd_addr=0xFFFF_FFFF → rsp_err=1, no wrap to low addresses.
- Write then read: write addr 3 data 0x0001, then read cmd_addr=1 with RAM[4]=0x0002 → rsp_min=0x0001, rsp_addr=3. Write to addr 1024 → no ram_ena pulse.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_* stable, cmd_ready=0 throughout; a cmd_valid presented during this time is not accepted until the cycle after the response handshake.
- Reset mid-op: assert rst_n=0 in CAPTURE → next cycle rsp_valid=0, all ram enables 0, cmd_ready=0; after release cmd_ready=1 and a fresh read completes normally.
